mips_cpu: RTL and testbench

// - Top-level 32-bit MIPS integer core, 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
// - Fetches from an external combinational instruction ROM (inst_rom) via address/chip-enable.
// - Executes the logic, shift and LUI subset below; no data-memory port, so MEM is a pass-through.

---
 rtl/mips_cpu_if.sv | 18 +
 rtl/mips_cpu.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_cpu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_if.sv
// mips_cpu_if: instruction-ROM fetch bus between the core (master) and a combinational ROM (slave).
interface mips_cpu_if;
    logic [31:0] o_rom_addr;
    logic        o_rom_ce;
    logic [31:0] i_rom_data;

    modport master (
        output o_rom_addr,
        output o_rom_ce,
        input  i_rom_data
    );

    modport slave (
        input  o_rom_addr,
        input  o_rom_ce,
        output i_rom_data
    );
endinterface

// File: rtl/mips_cpu.sv
// mips_cpu: 5-stage in-order MIPS integer core (logic/shift/LUI subset) with its register file.
// Define FORWARDING_EN to forward EX and MEM results into the ID operand muxes.

module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1_c,
    output logic [31:0] rdata2_c
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads observe a same-cycle write so WB-to-ID needs no extra slot.
    always_comb begin
        rdata1_c = '0;
        if (raddr1 == 5'd0)                rdata1_c = '0;
        else if (we && (waddr == raddr1))  rdata1_c = wdata;
        else                               rdata1_c = regs[raddr1];
    end

    always_comb begin
        rdata2_c = '0;
        if (raddr2 == 5'd0)                rdata2_c = '0;
        else if (we && (waddr == raddr2))  rdata2_c = wdata;
        else                               rdata2_c = regs[raddr2];
    end
endmodule

module mips_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    mips_cpu_if.master rom
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    logic [XLEN-1:0] pc;
    logic            ce;
    logic [XLEN-1:0] if_id_inst;

    alu_op_e         ex_aluop;
    logic [XLEN-1:0] ex_op1, ex_op2, ex_result;
    logic            ex_wreg;
    logic [RW-1:0]   ex_waddr;

    logic            mem_wreg;
    logic [RW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic            wb_wreg;
    logic [RW-1:0]   wb_waddr;
    logic [XLEN-1:0] wb_wdata;

    // Fetch: ce rises one edge after reset release, PC advances only while ce is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            ce <= 1'b0;
        end else begin
            ce <= 1'b1;
            if (ce) pc <= pc + 32'd4;
        end
    end

    assign rom.o_rom_addr = pc;
    assign rom.o_rom_ce   = ce;

    logic [5:0]      id_op, id_funct;
    logic [RW-1:0]   id_rs, id_rt, id_rd, id_shamt;
    logic [15:0]     id_imm;
    logic [XLEN-1:0] rf_rdata1_c, rf_rdata2_c, rs_val, rt_val;

    assign id_op    = if_id_inst[31:26];
    assign id_rs    = if_id_inst[25:21];
    assign id_rt    = if_id_inst[20:16];
    assign id_rd    = if_id_inst[15:11];
    assign id_shamt = if_id_inst[10:6];
    assign id_funct = if_id_inst[5:0];
    assign id_imm   = if_id_inst[15:0];

    mips_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_wreg),
        .waddr    (wb_waddr),
        .wdata    (wb_wdata),
        .raddr1   (id_rs),
        .raddr2   (id_rt),
        .rdata1_c (rf_rdata1_c),
        .rdata2_c (rf_rdata2_c)
    );

    // Operand select; wreg is never set for $0 so $0 is never forwarded.
    always_comb begin
`ifdef FORWARDING_EN
        if (ex_wreg && (ex_waddr == id_rs))        rs_val = ex_result;
        else if (mem_wreg && (mem_waddr == id_rs)) rs_val = mem_wdata;
        else                                       rs_val = rf_rdata1_c;
        if (ex_wreg && (ex_waddr == id_rt))        rt_val = ex_result;
        else if (mem_wreg && (mem_waddr == id_rt)) rt_val = mem_wdata;
        else                                       rt_val = rf_rdata2_c;
`else
        rs_val = rf_rdata1_c;
        rt_val = rf_rdata2_c;
`endif
    end

    alu_op_e         id_aluop;
    logic [XLEN-1:0] id_op1, id_op2;
    logic            id_dec_wreg;
    logic [RW-1:0]   id_waddr;

    // Decode; shifts carry the shift amount in op1 and the shifted value in op2.
    always_comb begin
        id_aluop    = ALU_NOP;
        id_op1      = '0;
        id_op2      = '0;
        id_dec_wreg = 1'b0;
        id_waddr    = '0;
        case (id_op)
            6'h00: begin
                id_waddr    = id_rd;
                id_dec_wreg = 1'b1;
                id_op1      = rs_val;
                id_op2      = rt_val;
                case (id_funct)
                    6'h24: id_aluop = ALU_AND;
                    6'h25: id_aluop = ALU_OR;
                    6'h26: id_aluop = ALU_XOR;
                    6'h27: id_aluop = ALU_NOR;
                    6'h00: begin id_aluop = ALU_SLL; id_op1 = XLEN'(id_shamt); end
                    6'h02: begin id_aluop = ALU_SRL; id_op1 = XLEN'(id_shamt); end
                    6'h03: begin id_aluop = ALU_SRA; id_op1 = XLEN'(id_shamt); end
                    6'h04: begin id_aluop = ALU_SLL; id_op1 = XLEN'(rs_val[4:0]); end
                    6'h06: begin id_aluop = ALU_SRL; id_op1 = XLEN'(rs_val[4:0]); end
                    6'h07: begin id_aluop = ALU_SRA; id_op1 = XLEN'(rs_val[4:0]); end
                    default: id_dec_wreg = 1'b0;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                id_waddr    = id_rt;
                id_dec_wreg = 1'b1;
                id_op1      = rs_val;
                id_op2      = XLEN'(id_imm);
                case (id_op)
                    6'h0C:   id_aluop = ALU_AND;
                    6'h0D:   id_aluop = ALU_OR;
                    default: id_aluop = ALU_XOR;
                endcase
            end
            6'h0F: begin
                id_waddr    = id_rt;
                id_dec_wreg = 1'b1;
                id_aluop    = ALU_OR;
                id_op1      = {id_imm, 16'h0000};
            end
            default: ;
        endcase
    end

    always_comb begin
        ex_result = '0;
        case (ex_aluop)
            ALU_OR:  ex_result = ex_op1 | ex_op2;
            ALU_AND: ex_result = ex_op1 & ex_op2;
            ALU_XOR: ex_result = ex_op1 ^ ex_op2;
            ALU_NOR: ex_result = ~(ex_op1 | ex_op2);
            ALU_SLL: ex_result = ex_op2 << ex_op1[4:0];
            ALU_SRL: ex_result = ex_op2 >> ex_op1[4:0];
            ALU_SRA: ex_result = XLEN'($signed(ex_op2) >>> ex_op1[4:0]);
            default: ex_result = '0;
        endcase
    end

    // Pipeline registers; reset turns every stage into a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_inst <= '0;
            ex_aluop   <= ALU_NOP;
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_wreg    <= 1'b0;
            ex_waddr   <= '0;
            mem_wreg   <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            wb_wreg    <= 1'b0;
            wb_waddr   <= '0;
            wb_wdata   <= '0;
        end else begin
            if_id_inst <= ce ? rom.i_rom_data : '0;
            ex_aluop   <= id_aluop;
            ex_op1     <= id_op1;
            ex_op2     <= id_op2;
            ex_wreg    <= id_dec_wreg && (id_waddr != 5'd0);
            ex_waddr   <= id_waddr;
            mem_wreg   <= ex_wreg;
            mem_waddr  <= ex_waddr;
            mem_wdata  <= ex_result;
            wb_wreg    <= mem_wreg;
            wb_waddr   <= mem_waddr;
            wb_wdata   <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed checks of fetch, reset, ALU subset and dependency handling of mips_cpu.
module tb_mips_cpu;
`ifdef FORWARDING_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 3;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wp;
    int   nz;
    logic [31:0] rom [0:63];

    mips_cpu_if rif ();

    mips_cpu dut (
        .clk (clk),
        .rst (rst),
        .rom (rif)
    );

    assign rif.i_rom_data = ((rif.o_rom_addr[31:8] == 24'h0) && (rif.o_rom_addr[1:0] == 2'b00))
                            ? rom[rif.o_rom_addr[7:2]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        wp = 0;
    endtask

    task automatic put(input logic [31:0] w);
        rom[wp] = w;
        wp++;
        for (int g = 0; g < GAP; g++) begin
            rom[wp] = 32'h0;
            wp++;
        end
    endtask

    task automatic count_nonzero(input int lo);
        nz = 0;
        for (int r = lo; r < 32; r++)
            if (dut.u_regfile.regs[r] !== 32'h0) nz++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // Run 1: reset, fetch sequence, first write latency, dependent chain
        clear_rom();
        put(32'h34011100);
        put(32'h34220020);
        put(32'h00222025);
        repeat (20) tick();
        check("reset_ce", 32'(rif.o_rom_ce), 32'h0);
        check("reset_addr", rif.o_rom_addr, 32'h0);
        count_nonzero(0);
        check("reset_gprs_nonzero", 32'(nz), 32'h0);
        rst = 1'b0;
        tick();
        check("e1_ce", 32'(rif.o_rom_ce), 32'h1);
        check("e1_addr", rif.o_rom_addr, 32'h0);
        tick();
        check("e2_addr", rif.o_rom_addr, 32'h4);
        tick();
        check("e3_addr", rif.o_rom_addr, 32'h8);
        tick();
        check("e4_addr", rif.o_rom_addr, 32'hC);
        tick();
        check("e5_r1_not_yet", dut.u_regfile.regs[1], 32'h0);
        tick();
        check("e6_r1_ori", dut.u_regfile.regs[1], 32'h0000_1100);
        repeat (14) tick();
        check("dep_r2", dut.u_regfile.regs[2], 32'h0000_1120);
        check("dep_r4", dut.u_regfile.regs[4], 32'h0000_1120);

        // Run 2: LUI/NOR and the remaining logic and shift operations
        rst = 1'b1;
        clear_rom();
        put(32'h3C03FFFF);
        put(32'h00032027);
        put(32'h00032903);
        put(32'h00033202);
        put(32'h38870F0F);
        put(32'h30E80FF0);
        put(32'h01074804);
        put(32'h01095007);
        put(32'h00665824);
        put(32'h00666026);
        put(32'h01036806);
        put(32'h00047100);
        repeat (2) tick();
        check("rst2_r1_cleared", dut.u_regfile.regs[1], 32'h0);
        rst = 1'b0;
        repeat (60) tick();
        check("lui_r3", dut.u_regfile.regs[3], 32'hFFFF_0000);
        check("nor_r4", dut.u_regfile.regs[4], 32'h0000_FFFF);
        check("sra_r5", dut.u_regfile.regs[5], 32'hFFFF_F000);
        check("srl_r6", dut.u_regfile.regs[6], 32'h00FF_FF00);
        check("xori_r7", dut.u_regfile.regs[7], 32'h0000_F0F0);
        check("andi_r8", dut.u_regfile.regs[8], 32'h0000_00F0);
        check("sllv_r9", dut.u_regfile.regs[9], 32'hF0F0_0000);
        check("srav_r10", dut.u_regfile.regs[10], 32'hFFFF_F0F0);
        check("and_r11", dut.u_regfile.regs[11], 32'h00FF_0000);
        check("xor_r12", dut.u_regfile.regs[12], 32'hFF00_FF00);
        check("srlv_r13", dut.u_regfile.regs[13], 32'h0000_FFFF);
        check("sll_r14", dut.u_regfile.regs[14], 32'h000F_FFF0);

        // Run 3: $0 write and unknown opcodes/functs are discarded
        rst = 1'b1;
        clear_rom();
        put(32'h34011100);
        put(32'h3400FFFF);
        put(32'hFC000000);
        put(32'h00221828);
        put(32'h2003ABCD);
        repeat (2) tick();
        rst = 1'b0;
        repeat (30) tick();
        check("r0_stays_zero", dut.u_regfile.regs[0], 32'h0);
        check("r1_written", dut.u_regfile.regs[1], 32'h0000_1100);
        check("r3_unknown_ops", dut.u_regfile.regs[3], 32'h0);
        count_nonzero(2);
        check("others_unchanged_nonzero", 32'(nz), 32'h0);

        // Run 4: one-cycle reset clears GPRs; mid-run reset discards in-flight work
        clear_rom();
        put(32'h34011100);
        put(32'h34020022);
        put(32'h34030033);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("pulse_r1_cleared", dut.u_regfile.regs[1], 32'h0);
        check("pulse_ce", 32'(rif.o_rom_ce), 32'h0);
        repeat (3) tick();
        check("mid_pre_addr", rif.o_rom_addr, 32'h8);
        rst = 1'b1;
        clear_rom();
        tick();
        rst = 1'b0;
        check("mid_rst_addr", rif.o_rom_addr, 32'h0);
        check("mid_rst_ce", 32'(rif.o_rom_ce), 32'h0);
        tick();
        check("mid_resume_ce", 32'(rif.o_rom_ce), 32'h1);
        check("mid_resume_addr", rif.o_rom_addr, 32'h0);
        tick();
        check("mid_resume_addr2", rif.o_rom_addr, 32'h4);
        repeat (12) tick();
        count_nonzero(0);
        check("mid_discarded_nonzero", 32'(nz), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
